sequence_generator_1011: RTL and testbench

Serial pattern transmitter that drives a bit-serial input such as the Moore 1011 sequence detector's `din`. On a start pulse it emits a fixed PAT_W-bit pattern MSB-first, one bit per clock, repeated rep_count times, with an optional run of gap bits between repetitions. It is used as the stimulus and traffic source for serial pattern detectors in the same design and benches.

---
 rtl/seqgen_pkg.sv | 19 +
 rtl/seqgen_lfsr.sv | 31 +++
 rtl/sequence_generator_1011.sv | 158 +++++++++++++++
 tb/tb_sequence_generator_1011.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seqgen_pkg.sv
// Shared types and constants for the serial pattern generator.
package seqgen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    // Fibonacci LFSR x^7 + x^6 + 1
    localparam int         LFSR_W     = 7;
    localparam logic [6:0] LFSR_SEED  = 7'h7F;
    localparam int         LFSR_TAP_A = 6;
    localparam int         LFSR_TAP_B = 5;

endpackage

// File: rtl/seqgen_lfsr.sv
// 7-bit Fibonacci LFSR gap-filler source; steps only when adv_i is high.
module seqgen_lfsr
    import seqgen_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic adv_i,
    output logic bit_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[LFSR_W-1];

endmodule

// File: rtl/sequence_generator_1011.sv
// Serial pattern transmitter: PATTERN MSB-first, rep_count times, gaps between.
// Define SEQGEN_LFSR_GAP_EN to fill gaps with LFSR bits instead of zeros.
module sequence_generator_1011
    import seqgen_pkg::*;
#(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int             GAP_W   = 4,
    parameter int             REP_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [REP_W-1:0] rep_count,
    input  logic [GAP_W-1:0] gap_bits,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_cfg_q, gap_cfg_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gap_adv;
    logic             gap_bit;

`ifdef SEQGEN_LFSR_GAP_EN
    seqgen_lfsr u_lfsr (
        .clk_i (clock),
        .rst_i (reset),
        .adv_i (gap_adv),
        .bit_o (gap_bit)
    );
`else
    assign gap_bit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        gap_cfg_d = gap_cfg_q;
        gap_cnt_d = gap_cnt_q;
        dout_d    = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        gap_adv   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    rep_d     = rep_count;
                    gap_cfg_d = gap_bits;
                    idx_d     = IDX_MAX;
                    if (rep_count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        dout_d  = PATTERN[PAT_W-1];
                        valid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (idx_q != '0) begin
                    idx_d   = idx_q - IDX_W'(1);
                    dout_d  = PATTERN[idx_d];
                    valid_d = 1'b1;
                end else begin
                    rep_d = rep_q - REP_W'(1);
                    if (rep_d == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (gap_cfg_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_cfg_q - GAP_W'(1);
                        dout_d    = gap_bit;
                        valid_d   = 1'b1;
                        gap_adv   = 1'b1;
                    end else begin
                        idx_d   = IDX_MAX;
                        dout_d  = PATTERN[PAT_W-1];
                        valid_d = 1'b1;
                    end
                end
            end
            GAP: begin
                // gap_cnt_q holds the gap bits still owed after the current one
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    dout_d    = gap_bit;
                    valid_d   = 1'b1;
                    gap_adv   = 1'b1;
                end else begin
                    state_d = SHIFT;
                    idx_d   = IDX_MAX;
                    dout_d  = PATTERN[PAT_W-1];
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            dout_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            gap_adv = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= IDX_MAX;
            rep_q     <= '0;
            gap_cfg_q <= '0;
            gap_cnt_q <= '0;
            dout_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            gap_cfg_q <= gap_cfg_d;
            gap_cnt_q <= gap_cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sequence_generator_1011.sv
// Directed self-checking bench for sequence_generator_1011 (default build).
module tb_sequence_generator_1011;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] rep_count;
    logic [3:0] gap_bits;
    logic       abort;
    logic       dout;
    logic       dout_valid;
    logic       busy;
    logic       done;

    int         n_chk;
    int         n_fail;
    logic [3:0] sh;
    int         det;

    sequence_generator_1011 dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rep_count  (rep_count),
        .gap_bits   (gap_bits),
        .abort      (abort),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Issue start at a negedge; returns in cycle 1 (first output cycle).
    task automatic kick(input logic [7:0] rc, input logic [3:0] gb);
        rep_count = rc;
        gap_bits  = gb;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic expect_bits(input string tag, input logic [15:0] bits,
                               input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, " valid"}, 32'(dout_valid), 32'd1);
            chk({tag, " dout"}, 32'(dout), 32'(bits[n-1-i]));
            sh = {sh[2:0], dout};
            if (dout_valid && sh == 4'b1011) det++;
            step();
        end
    endtask

    task automatic run_count(output int nvalid, output bit got_done);
        nvalid   = 0;
        got_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (dout_valid) nvalid++;
            step();
        end
    endtask

    int nv;
    bit gd;
    bit saw_done;

    initial begin
        n_chk = 0; n_fail = 0; sh = '0; det = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        rep_count = '0; gap_bits = '0;
        step(); step();
        chk("rst dout", 32'(dout), 32'd0);
        chk("rst valid", 32'(dout_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        reset = 1'b0;
        step();

        // single repetition
        kick(8'd1, 4'd0);
        chk("t1 busy", 32'(busy), 32'd1);
        expect_bits("t1", 16'b1011, 4);
        chk("t1 done", 32'(done), 32'd1);
        chk("t1 done valid", 32'(dout_valid), 32'd0);
        chk("t1 done busy", 32'(busy), 32'd1);
        step();
        chk("t1 idle busy", 32'(busy), 32'd0);
        chk("t1 idle done", 32'(done), 32'd0);

        // two repetitions, gap of two
        sh = '0; det = 0;
        kick(8'd2, 4'd2);
        expect_bits("t2", 16'b1011001011, 10);
        chk("t2 done", 32'(done), 32'd1);
        chk("t2 det", 32'(det), 32'd2);
        step();

        // three back-to-back repetitions
        sh = '0; det = 0;
        kick(8'd3, 4'd0);
        expect_bits("t3", 16'b101110111011, 12);
        chk("t3 done", 32'(done), 32'd1);
        chk("t3 det", 32'(det), 32'd3);
        step();

        // zero repetitions
        kick(8'd0, 4'd5);
        chk("t4 done", 32'(done), 32'd1);
        chk("t4 busy", 32'(busy), 32'd1);
        chk("t4 valid", 32'(dout_valid), 32'd0);
        step();
        chk("t4 idle busy", 32'(busy), 32'd0);
        chk("t4 idle valid", 32'(dout_valid), 32'd0);

        // start while busy is ignored
        kick(8'd2, 4'd0);
        nv = (dout_valid) ? 1 : 0;
        step();
        start = 1'b1;
        if (dout_valid) nv++;
        step();
        start = 1'b0;
        begin
            int rest;
            run_count(rest, gd);
            nv += rest;
        end
        chk("t5a nvalid", 32'(nv), 32'd8);
        chk("t5a done", 32'(gd), 32'd1);
        step();
        step();
        chk("t5a no restart", 32'(busy), 32'd0);

        // abort during transmission
        kick(8'd2, 4'd1);
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5b valid", 32'(dout_valid), 32'd0);
        chk("t5b busy", 32'(busy), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) saw_done = 1'b1;
            step();
        end
        chk("t5b no done", 32'(saw_done), 32'd0);

        // abort wins over start in IDLE
        abort = 1'b1;
        kick(8'd1, 4'd0);
        abort = 1'b0;
        chk("t5c busy", 32'(busy), 32'd0);
        chk("t5c valid", 32'(dout_valid), 32'd0);

        // asynchronous reset mid-shift
        kick(8'd1, 4'd0);
        step();
        #2 reset = 1'b1;
        #1;
        chk("t6 rst dout", 32'(dout), 32'd0);
        chk("t6 rst valid", 32'(dout_valid), 32'd0);
        chk("t6 rst busy", 32'(busy), 32'd0);
        chk("t6 rst done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        step();
        kick(8'd1, 4'd0);
        expect_bits("t6 fresh", 16'b1011, 4);
        chk("t6 done", 32'(done), 32'd1);
        step();

        // gap of three zero bits
        kick(8'd2, 4'd3);
        expect_bits("t7", 16'b10110001011, 11);
        chk("t7 done", 32'(done), 32'd1);
        step();

        // maximum gap width
        kick(8'd2, 4'd15);
        run_count(nv, gd);
        chk("t8 nvalid", 32'(nv), 32'd23);
        chk("t8 done", 32'(gd), 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
